u21_cfg_seq: RTL and testbench
==============================

Name: u21_cfg_seq

Overview:
Sequencer directly upstream of u21_ref and downstream of the function-request source. Accepts a 4-bit two-input truth table over a valid/ready handshake and walks u21_ref through pins 0..3. Captures each 3-bit pin wiring code and returns the packed 12-bit wiring word over a valid/ready handshake. Also flags any out-of-range code.

Parameters:
- REF_LAT, default 1: clock cycles from a u21_ref pin/func change to the matching wiring code being valid. Legal range 0..3.

Ports:
- clk  input  1: system clock, rising edge.
- rst_n  input  1: asynchronous active-low reset.
- req_valid  input  1: request present.
- req_ready  output  1: sequencer can accept a request.
- req_func  input  4: truth table; bit k is the output for (b,a)=k.
- ref_func  output  4: drives u21_ref func.
- ref_pin  output  2: drives u21_ref pin.
- ref_wiring  input  3: u21_ref wiring result. 0=tie low, 1=tie high, 2=input a, 3=input b.
- rsp_valid  output  1: response present.
- rsp_ready  input  1: consumer takes the response.
- rsp_func  output  4: function of the current response.
- rsp_wiring  output  12: packed codes; pin i occupies bits [3i+2:3i].
- rsp_err  output  1: at least one captured code is >3.

Behaviour:
- Reset (async assert, sync-deasserted use) drives all outputs to 0 except req_ready=1. Register state: state=IDLE, issue counter=0, capture counter=0, wiring accumulator=0. Any operation in flight is discarded; no response is produced for it.
- States and transitions:
  - IDLE: req_ready=1. On req_valid&req_ready: latch req_func into ref_func and rsp_func, set ref_pin=0, clear accumulator, go to RUN.
  - RUN: ref_pin increments once per cycle 0→1→2→3, then holds at 3. ref_wiring is sampled REF_LAT cycles after each pin value is first presented and written to slot [3p+2:3p]. After slot 3 is written, go to RESP.
  - RESP: rsp_valid=1. rsp_wiring, rsp_func and rsp_err are stable until the handshake completes. On rsp_ready, go to IDLE, set ref_pin=0 and leave ref_func unchanged.
- Timing, with E0 = the acceptance edge:
  - Pin p is presented from E0 to E(p+1).
  - Its code is sampled at edge E(p+1+REF_LAT).
  - rsp_valid rises after E(4+REF_LAT), i.e. 5 cycles for REF_LAT=1 and 4 cycles for REF_LAT=0.
- ref_func stays constant from E0 until the next acceptance.
- req_ready=(state==IDLE), so at most one request is in flight. A new request can be accepted no earlier than the cycle after the response handshake.
- rsp_err is the OR of bit 2 of all four captured codes. Codes are stored unmodified.
- rsp_valid is never withdrawn without rsp_ready. A rsp_ready held high with rsp_valid low has no effect.
- req_valid while req_ready=0 is ignored. The requester must hold it until acceptance.

Optional Feature:
- Macro U21_CACHE_EN.
- When defined: a 16-entry cache indexed by req_func, each entry holding a valid bit and 12 bits of wiring. All valid bits are cleared on reset.
  - On acceptance with a hit: RUN is skipped, ref_pin stays 0, rsp_valid rises after E1, and rsp_err=0.
  - On a miss: normal RUN. The entry is filled on entry to RESP only if rsp_err=0.
- When undefined: no cache storage, and every request runs the full RUN sequence.

Test Plan:
- Reset, then req_func=4'b0001 with the bench modelling u21_ref at REF_LAT=1 → rsp_wiring=12'h4D0, rsp_err=0, rsp_valid first high 5 cycles after acceptance, ref_pin sequence 0,1,2,3.
- Back-to-back requests 4'b0000, 4'b1000, 4'b1111 with rsp_ready tied high → responses 12'h000, 12'h691, 12'h200 in order; req_ready low from acceptance through each response handshake.
- rsp_ready held low 10 cycles after 4'b0110 → rsp_wiring=12'h610 held stable and rsp_valid held high throughout; req_ready stays 0; req_valid pulses are ignored.
- Bench model returns code 3'b101 for pin 2 → rsp_err=1, rsp_wiring[8:6]=3'b101.
- rst_n asserted at the cycle ref_pin=2 → all outputs at reset values immediately; the next request completes correctly with no stale slots.
- With U21_CACHE_EN defined, request 4'b0001 twice → first response after 5 cycles, second after 1 cycle with 12'h4D0 and ref_pin held at 0.

Source files
------------

// File: rtl/u21_cfg_seq.sv
// u21_cfg_seq: walks u21_ref through pins 0..3 for one truth table and returns the packed wiring word.
// Optional feature macro U21_CACHE_EN: a 16-entry wiring cache indexed by function that skips the pin walk on a hit.
module u21_cfg_seq #(
    parameter int unsigned REF_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_func,
    output logic [3:0]  ref_func,
    output logic [1:0]  ref_pin,
    input  logic [2:0]  ref_wiring,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [3:0]  rsp_func,
    output logic [11:0] rsp_wiring,
    output logic        rsp_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HIT, S_RESP} state_t;

    localparam logic [2:0] LAT = 3'(REF_LAT);

    state_t      state_q, state_d;
    logic [3:0]  func_q, func_d;
    logic [1:0]  pin_q, pin_d;
    logic [2:0]  issue_q, issue_d;
    logic [1:0]  cap_q, cap_d;
    logic [11:0] acc_q, acc_d;
    logic        accept, capture, last_capture, hit;
    logic [11:0] hit_wiring;

    // A code above 3 is out of range; bit 2 of any slot flags it.
    function automatic logic code_err(input logic [11:0] w);
        return w[2] | w[5] | w[8] | w[11];
    endfunction

    assign accept       = req_valid && (state_q == S_IDLE);
    assign capture      = (state_q == S_RUN) && (issue_q >= LAT);
    assign last_capture = capture && (cap_q == 2'd3);

`ifdef U21_CACHE_EN
    logic [15:0] cache_vld_q;
    logic [11:0] cache_data_q [16];
    logic        fill;

    assign hit        = cache_vld_q[req_func];
    assign hit_wiring = cache_data_q[req_func];
    assign fill       = last_capture && !code_err(acc_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_vld_q <= '0;
        end else if (fill) begin
            cache_vld_q[func_q] <= 1'b1;
        end
    end

    // NOTE: the data array has no reset; the valid bits alone decide whether an entry is used.
    always_ff @(posedge clk) begin
        if (fill) begin
            cache_data_q[func_q] <= acc_d;
        end
    end
`else
    assign hit        = 1'b0;
    assign hit_wiring = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)       state_d = hit ? S_HIT : S_RUN;
            S_RUN:   if (last_capture) state_d = S_RESP;
            S_HIT:                     state_d = S_RESP;
            S_RESP:  if (rsp_ready)    state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        rsp_valid  = (state_q == S_RESP);
        ref_func   = func_q;
        ref_pin    = pin_q;
        rsp_func   = func_q;
        rsp_wiring = acc_q;
        rsp_err    = code_err(acc_q);
    end

    // NOTE: every next-state variable takes its current value first, so no path can infer a latch.
    always_comb begin
        func_d  = func_q;
        pin_d   = pin_q;
        issue_d = issue_q;
        cap_d   = cap_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    func_d  = req_func;
                    pin_d   = 2'd0;
                    issue_d = 3'd0;
                    cap_d   = 2'd0;
                    acc_d   = hit ? hit_wiring : 12'd0;
                end
            end
            S_RUN: begin
                issue_d = issue_q + 3'd1;
                if (pin_q != 2'd3) pin_d = pin_q + 2'd1;
                if (capture) cap_d = cap_q + 2'd1;
                // Slot index follows the capture counter, which lags the pin by REF_LAT cycles.
                for (int s = 0; s < 4; s++) begin
                    if (capture && (cap_q == 2'(s))) acc_d[3*s +: 3] = ref_wiring;
                end
            end
            S_RESP: begin
                if (rsp_ready) pin_d = 2'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func_q  <= '0;
            pin_q   <= '0;
            issue_q <= '0;
            cap_q   <= '0;
            acc_q   <= '0;
        end else begin
            func_q  <= func_d;
            pin_q   <= pin_d;
            issue_q <= issue_d;
            cap_q   <= cap_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_u21_cfg_seq.sv
// Bench for u21_cfg_seq: models u21_ref at REF_LAT=1 and checks responses against a per-pin code table.
// Build with U21_CACHE_EN defined to exercise the wiring cache.
module tb_u21_cfg_seq;

    localparam int REF_LAT = 1;
`ifdef U21_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_func;
    logic [3:0]  ref_func;
    logic [1:0]  ref_pin;
    logic [2:0]  ref_wiring = '0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_func;
    logic [11:0] rsp_wiring;
    logic        rsp_err;

    int          checks = 0;
    int          errors = 0;
    bit          inj = 1'b0;
    bit          cv_m [16];
    logic [11:0] cd_m [16];
    logic [11:0] w1, w2;
    int          lat1, lat2;

    u21_cfg_seq #(.REF_LAT(REF_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
        .ref_func(ref_func), .ref_pin(ref_pin), .ref_wiring(ref_wiring),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_func(rsp_func), .rsp_wiring(rsp_wiring), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // u21_ref stand-in: wiring code per (function, pin); inj forces an out-of-range code on pin 2.
    function automatic logic [2:0] code_of(input logic [3:0] f, input int p, input bit bad);
        int c [4];
        if (bad && p == 2) return 3'b101;
        case (f)
            4'b0000: c = '{0, 0, 0, 0};
            4'b0001: c = '{0, 2, 3, 2};
            4'b1000: c = '{1, 2, 2, 3};
            4'b1111: c = '{0, 0, 0, 1};
            4'b0110: c = '{0, 2, 0, 3};
            default: for (int i = 0; i < 4; i++) c[i] = (int'(f) + 3 * i) % 4;
        endcase
        return 3'(c[p]);
    endfunction

    function automatic logic [11:0] pack(input logic [3:0] f, input bit bad);
        logic [11:0] w = '0;
        for (int p = 0; p < 4; p++) w[3*p +: 3] = code_of(f, p, bad);
        return w;
    endfunction

    always @(posedge clk) ref_wiring <= code_of(ref_func, int'(ref_pin), inj);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cache_model();
        for (int i = 0; i < 16; i++) begin
            cv_m[i] = 1'b0;
            cd_m[i] = '0;
        end
    endtask

    // Called just after a falling edge; returns just after a falling edge once the response is taken.
    task automatic txn(input logic [3:0] f, input int stall, input bit tie,
                       output logic [11:0] obs_w, output int obs_lat);
        bit          hit;
        logic [11:0] exp_w;
        logic        exp_err;
        int          exp_lat;
        int          k;
        hit     = CACHE_ON && cv_m[f];
        exp_w   = hit ? cd_m[f] : pack(f, inj);
        exp_err = exp_w[2] | exp_w[5] | exp_w[8] | exp_w[11];
        exp_lat = hit ? 1 : 4 + REF_LAT;
        if (tie) rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_func  = f;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_func  = 4'($urandom);
        check("ref_func_latched", 32'(ref_func), 32'(f));
        check("pin_at_accept", 32'(ref_pin), 32'd0);
        check("ready_after_accept", 32'(req_ready), 32'd0);
        k = 0;
        while (!rsp_valid && k < 30) begin
            @(negedge clk);
            k++;
            check("pin_walk", 32'(ref_pin), hit ? 32'd0 : 32'(k > 3 ? 3 : k));
            if (!rsp_valid) check("ready_busy", 32'(req_ready), 32'd0);
        end
        obs_w   = rsp_wiring;
        obs_lat = k;
        check("latency", 32'(k), 32'(exp_lat));
        check("rsp_wiring", 32'(rsp_wiring), 32'(exp_w));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("rsp_func", 32'(rsp_func), 32'(f));
        if (CACHE_ON && !hit && !exp_err) begin
            cv_m[f] = 1'b1;
            cd_m[f] = exp_w;
        end
        for (int i = 0; i < (tie ? 0 : stall); i++) begin
            req_valid = i[0];
            req_func  = ~f;
            @(negedge clk);
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_wiring", 32'(rsp_wiring), 32'(exp_w));
            check("stall_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("valid_dropped", 32'(rsp_valid), 32'd0);
        check("ready_back", 32'(req_ready), 32'd1);
        check("pin_home", 32'(ref_pin), 32'd0);
        check("ref_func_kept", 32'(ref_func), 32'(f));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ref_pin"}, 32'(ref_pin), 32'd0);
        check({tag, "_ref_func"}, 32'(ref_func), 32'd0);
        check({tag, "_rsp_func"}, 32'(rsp_func), 32'd0);
        check({tag, "_rsp_wiring"}, 32'(rsp_wiring), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_func  = '0;
        rsp_ready = 1'b0;
        clear_cache_model();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // NOR: full walk, fixed latency.
        txn(4'b0001, 0, 1'b0, w1, lat1);
        check("nor_word", 32'(w1), 32'h4D0);
        check("nor_latency", 32'(lat1), 32'd5);

        // Back-to-back with the consumer always ready.
        txn(4'b0000, 0, 1'b1, w1, lat1);
        check("b2b_0000", 32'(w1), 32'h000);
        txn(4'b1000, 0, 1'b1, w1, lat1);
        check("b2b_1000", 32'(w1), 32'h691);
        txn(4'b1111, 0, 1'b1, w1, lat1);
        check("b2b_1111", 32'(w1), 32'h200);

        // Consumer stalls for 10 cycles while stray requests arrive.
        txn(4'b0110, 10, 1'b0, w1, lat1);
        check("stall_word", 32'(w1), 32'h610);

        // Out-of-range code on pin 2.
        inj = 1'b1;
        txn(4'b0011, 0, 1'b0, w1, lat1);
        inj = 1'b0;
        check("err_slot2", 32'(w1[8:6]), 32'b101);
        check("err_flag_last", 32'(rsp_err), 32'd1);

        // Reset asserted mid-walk at pin 2.
        req_valid = 1'b1;
        req_func  = 4'b0110;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat1 = 0;
        while (ref_pin != 2'd2 && lat1 < 10) begin
            @(negedge clk);
            lat1++;
        end
        check("reached_pin2", 32'(ref_pin), 32'd2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        clear_cache_model();
        @(negedge clk);
        rst_n = 1'b1;
        txn(4'b1000, 0, 1'b0, w1, lat1);
        check("after_reset_word", 32'(w1), 32'h691);

        // Randomised traffic.
        for (int n = 0; n < 16; n++) begin
            inj = ($urandom_range(0, 3) == 0);
            txn(4'($urandom), int'($urandom_range(0, 3)), 1'($urandom), w1, lat1);
        end
        inj = 1'b0;

        // Same function twice from a clean reset: a cache build answers the repeat in one cycle.
        rst_n = 1'b0;
        clear_cache_model();
        @(negedge clk);
        rst_n = 1'b1;
        txn(4'b0001, 0, 1'b0, w1, lat1);
        txn(4'b0001, 0, 1'b0, w2, lat2);
        check("repeat_first_lat", 32'(lat1), 32'd5);
        check("repeat_second_lat", 32'(lat2), CACHE_ON ? 32'd1 : 32'd5);
        check("repeat_second_word", 32'(w2), 32'h4D0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
